// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: captures instruction and PC+4, handles stall/flush with
// stretchable bubble insertion. Optional statistics counters enabled by IF_ID_STATS_EN.
module if_id_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc_plus4,
  input  logic              if_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [5:0]        id_funct,
  output logic [15:0]       id_imm16,
  output logic [25:0]       id_jaddr,
  output logic              busy_bubble
`ifdef IF_ID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int unsigned BCNT_W = 3;
  localparam logic [BCNT_W-1:0] RELOAD = BCNT_W'(FLUSH_DEPTH - 1);

  generate
    if (DATA_W != 32 || FLUSH_DEPTH < 1 || FLUSH_DEPTH > 7 || CNT_W < 1) begin : g_bad_param
      $fatal(1, "if_id_stage_reg: illegal parameters (DATA_W must be 32, FLUSH_DEPTH 1..7)");
    end
  endgenerate

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t            state;
  logic [BCNT_W-1:0] bcnt;

  // busy_bubble marks bubbles emitted while in the BUBBLE state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      bcnt        <= '0;
      id_instr    <= NOP_WORD;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      busy_bubble <= 1'b0;
    end else if (flush) begin
      id_instr    <= NOP_WORD;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      busy_bubble <= (state == BUBBLE);
      if (FLUSH_DEPTH > 1) begin
        bcnt  <= RELOAD;
        state <= BUBBLE;
      end
    end else if (state == BUBBLE) begin
      busy_bubble <= 1'b1;
      if (!stall) begin
        id_instr    <= NOP_WORD;
        id_pc_plus4 <= '0;
        id_valid    <= 1'b0;
        bcnt        <= bcnt - BCNT_W'(1);
        if (bcnt == BCNT_W'(1)) state <= RUN;
      end
    end else if (!stall) begin
      busy_bubble <= 1'b0;
      if (if_valid) begin
        id_instr    <= if_instr;
        id_pc_plus4 <= if_pc_plus4;
        id_valid    <= 1'b1;
      end else begin
        id_instr    <= NOP_WORD;
        id_pc_plus4 <= '0;
        id_valid    <= 1'b0;
      end
    end
  end

  assign id_opcode = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_rd     = id_instr[15:11];
  assign id_shamt  = id_instr[10:6];
  assign id_funct  = id_instr[5:0];
  assign id_imm16  = id_instr[15:0];
  assign id_jaddr  = id_instr[25:0];

`ifdef IF_ID_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)           flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
